// File: rtl/mfe_scheduler.sv
// 3x3 median-filter scheduler: walks every pixel of the frame in row-major order.
// For each pixel it fetches the nine neighbours, streams them to the median datapath,
// waits for the median result and writes it to the result memory at the pixel's address.
module mfe_scheduler #(
    parameter int IMG_W = 128,
    parameter int IMG_H = 128
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ready,
    output logic        busy,
    output logic [13:0] iaddr,
    input  logic [7:0]  idata,
    output logic        win_valid,
    output logic [3:0]  win_idx,
    output logic [7:0]  win_data,
    output logic        win_last,
    input  logic        med_valid,
    input  logic [7:0]  med_data,
    output logic        wen,
    output logic [13:0] addr,
    output logic [7:0]  data_wr,
    output logic        done
);

    localparam int AW = 14;
    localparam logic [AW-1:0] LAST = AW'(IMG_W * IMG_H - 1);
    localparam logic [AW-1:0] W_M1 = AW'(IMG_W - 1);
    localparam logic [AW-1:0] H_M1 = AW'(IMG_H - 1);
    localparam logic [AW-1:0] WL   = AW'(IMG_W);

    typedef enum logic [1:0] {IDLE, FETCH, WAIT, WRITE} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] p_q, p_d;
    logic [AW-1:0] r_q, r_d;
    logic [AW-1:0] c_q, c_d;
    logic [3:0]    k_q, k_d;
    logic [AW-1:0] iaddr_q;
    logic          wv_q, wv_d;
    logic [3:0]    widx_q, widx_d;
    logic          wpad_q, wpad_d;
    logic          wlast_q, wlast_d;
    logic [7:0]    med_q, med_d;
    logic          done_q, done_d;

    logic [1:0]    krow, kcol;
    logic          nb_inb;
    logic [AW-1:0] nr, nc, nb_addr;

    // Neighbour offset for index k: row/col selector 0,1,2 meaning -1,0,+1
    always_comb begin
        krow = 2'd0;
        kcol = 2'd0;
        case (k_q)
            4'd0: begin krow = 2'd0; kcol = 2'd0; end
            4'd1: begin krow = 2'd0; kcol = 2'd1; end
            4'd2: begin krow = 2'd0; kcol = 2'd2; end
            4'd3: begin krow = 2'd1; kcol = 2'd0; end
            4'd4: begin krow = 2'd1; kcol = 2'd1; end
            4'd5: begin krow = 2'd1; kcol = 2'd2; end
            4'd6: begin krow = 2'd2; kcol = 2'd0; end
            4'd7: begin krow = 2'd2; kcol = 2'd1; end
            default: begin krow = 2'd2; kcol = 2'd2; end
        endcase
    end

    // Bounds test and source address of the current neighbour; the address is
    // only meaningful when in bounds, so modular wrap of nr/nc is harmless.
    always_comb begin
        nb_inb  = !((krow == 2'd0 && r_q == '0) || (krow == 2'd2 && r_q == H_M1) ||
                    (kcol == 2'd0 && c_q == '0) || (kcol == 2'd2 && c_q == W_M1));
        nr      = r_q + AW'(krow) - AW'(1);
        nc      = c_q + AW'(kcol) - AW'(1);
        nb_addr = nr * WL + nc;
    end

    // Padded neighbours leave the source address where it was
    assign iaddr     = (state_q == FETCH && nb_inb) ? nb_addr : iaddr_q;
    assign busy      = (state_q != IDLE);
    assign wen       = (state_q == WRITE);
    assign addr      = (state_q == WRITE) ? p_q : '0;
    assign data_wr   = (state_q == WRITE) ? med_q : '0;
    assign win_valid = wv_q;
    assign win_idx   = widx_q;
    assign win_last  = wlast_q;
    assign win_data  = (wv_q && !wpad_q) ? idata : '0;
    assign done      = done_q;

    // Next-state and counter update for the per-pixel fetch/wait/write loop
    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        r_d     = r_q;
        c_d     = c_q;
        k_d     = k_q;
        wv_d    = 1'b0;
        wlast_d = 1'b0;
        widx_d  = widx_q;
        wpad_d  = wpad_q;
        med_d   = med_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (ready) begin
                    state_d = FETCH;
                    p_d     = '0;
                    r_d     = '0;
                    c_d     = '0;
                    k_d     = '0;
                end
            end
            FETCH: begin
                wv_d    = 1'b1;
                widx_d  = k_q;
                wpad_d  = !nb_inb;
                wlast_d = (k_q == 4'd8);
                if (k_q == 4'd8) begin
                    state_d = WAIT;
                    k_d     = '0;
                end else begin
                    k_d = k_q + 4'd1;
                end
            end
            WAIT: begin
                if (med_valid) begin
                    med_d   = med_data;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (p_q == LAST) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = FETCH;
                    k_d     = '0;
                    p_d     = p_q + AW'(1);
                    if (c_q == W_M1) begin
                        c_d = '0;
                        r_d = r_q + AW'(1);
                    end else begin
                        c_d = c_q + AW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, all cleared by asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            p_q     <= '0;
            r_q     <= '0;
            c_q     <= '0;
            k_q     <= '0;
            iaddr_q <= '0;
            wv_q    <= 1'b0;
            widx_q  <= '0;
            wpad_q  <= 1'b0;
            wlast_q <= 1'b0;
            med_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            r_q     <= r_d;
            c_q     <= c_d;
            k_q     <= k_d;
            iaddr_q <= iaddr;
            wv_q    <= wv_d;
            widx_q  <= widx_d;
            wpad_q  <= wpad_d;
            wlast_q <= wlast_d;
            med_q   <= med_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_mfe_scheduler.sv
// Self-checking bench for mfe_scheduler on a 128x3 image: the width keeps the
// corner/interior/last-pixel address patterns, the height keeps a frame short.
module tb_mfe_scheduler;

    localparam int W = 128;
    localparam int H = 3;
    localparam int N = W * H;

    logic        clk = 1'b0;
    logic        reset, ready, busy;
    logic [13:0] iaddr;
    logic [7:0]  idata;
    logic        win_valid, win_last;
    logic [3:0]  win_idx;
    logic [7:0]  win_data;
    logic        med_valid;
    logic [7:0]  med_data;
    logic        wen;
    logic [13:0] addr;
    logic [7:0]  data_wr;
    logic        done;

    always #5 clk = ~clk;

    mfe_scheduler #(.IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .reset(reset), .ready(ready), .busy(busy),
        .iaddr(iaddr), .idata(idata),
        .win_valid(win_valid), .win_idx(win_idx), .win_data(win_data), .win_last(win_last),
        .med_valid(med_valid), .med_data(med_data),
        .wen(wen), .addr(addr), .data_wr(data_wr), .done(done)
    );

    // Source image: nonzero pixels so padding is visible as a zero
    logic [7:0] img [0:N-1];
    always @(posedge clk) idata <= (int'(iaddr) < N) ? img[iaddr] : 8'hEE;

    int n_chk  = 0;
    int n_fail = 0;
    int exp_prev;
    int cap_ia [0:N-1][0:8];
    logic [7:0] cap_wd [0:N-1][0:8];

    typedef struct {
        int         p;
        int         wt;
        logic [7:0] md;
        int         ia [9];
    } vec_t;
    vec_t tbl [3];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Neighbour k of pixel p: source address, or -1 when outside the image
    function automatic int nb(input int p, input int k);
        int r, c, nr, nc;
        r  = p / W;
        c  = p % W;
        nr = r + k / 3 - 1;
        nc = c + k % 3 - 1;
        if (nr < 0 || nr >= H || nc < 0 || nc >= W) return -1;
        return nr * W + nc;
    endfunction

    function automatic logic [7:0] elem(input int a);
        return (a < 0) ? 8'h00 : img[a];
    endfunction

    // One pixel from FETCH k=0 (called #1 after the edge entering it) through WRITE.
    // Noise on ready/med_valid outside WAIT must have no effect.
    task automatic run_pixel(input int p, input int wt, input logic [7:0] md, input bit cap);
        int a [9];
        for (int k = 0; k < 9; k++) a[k] = nb(p, k);
        for (int k = 0; k < 9; k++) begin
            chk("fetch_busy", busy, 1);
            chk("fetch_wen", wen, 0);
            chk("fetch_done", done, 0);
            if (a[k] >= 0) exp_prev = a[k];
            chk("iaddr", iaddr, exp_prev);
            if (cap) cap_ia[p][k] = int'(iaddr);
            if (k == 0) begin
                chk("win_valid_k0", win_valid, 0);
            end else begin
                chk("win_valid", win_valid, 1);
                chk("win_idx", win_idx, k - 1);
                chk("win_data", win_data, elem(a[k-1]));
                chk("win_last", win_last, 0);
                if (cap) cap_wd[p][k-1] = win_data;
            end
            ready     = 1'($urandom);
            med_valid = 1'($urandom);
            med_data  = 8'($urandom);
            step();
        end
        for (int w = 0; w < wt; w++) begin
            if (w == 0) begin
                chk("win_valid_k8", win_valid, 1);
                chk("win_idx_k8", win_idx, 8);
                chk("win_data_k8", win_data, elem(a[8]));
                chk("win_last_k8", win_last, 1);
                if (cap) cap_wd[p][8] = win_data;
            end else begin
                chk("wait_win_valid", win_valid, 0);
            end
            chk("wait_wen", wen, 0);
            chk("wait_busy", busy, 1);
            chk("wait_iaddr", iaddr, exp_prev);
            med_valid = (w == wt - 1);
            med_data  = (w == wt - 1) ? md : 8'($urandom);
            ready     = 1'($urandom);
            step();
        end
        chk("write_wen", wen, 1);
        chk("write_addr", addr, p);
        chk("write_data", data_wr, md);
        chk("write_busy", busy, 1);
        chk("write_win_valid", win_valid, 0);
        med_valid = (p == N - 1) ? 1'b0 : 1'($urandom);
        med_data  = 8'($urandom);
        ready     = (p == N - 1) ? 1'b0 : 1'($urandom);
        step();
        if (p == N - 1) begin
            chk("end_busy", busy, 0);
            chk("end_done", done, 1);
            chk("end_wen", wen, 0);
            step();
            chk("done_pulse_len", done, 0);
            chk("idle_busy", busy, 0);
        end
    endtask

    initial begin
        int wt;
        logic [7:0] md;

        tbl[0].p = 0;     tbl[0].wt = 1; tbl[0].md = 8'h11;
        tbl[0].ia = '{-1, -1, -1, -1, 0, 1, -1, 128, 129};
        tbl[1].p = 129;   tbl[1].wt = 3; tbl[1].md = 8'h5A;
        tbl[1].ia = '{0, 1, 2, 128, 129, 130, 256, 257, 258};
        tbl[2].p = N - 1; tbl[2].wt = 2; tbl[2].md = 8'hC3;
        tbl[2].ia = '{254, 255, -1, 382, 383, -1, -1, -1, -1};

        for (int i = 0; i < N; i++) img[i] = 8'($urandom_range(1, 255));
        reset = 1'b1; ready = 1'b1; med_valid = 1'b0; med_data = 8'h00;
        exp_prev = 0;

        // Reset state, with ready held high throughout
        repeat (3) step();
        chk("rst_busy", busy, 0);
        chk("rst_wen", wen, 0);
        chk("rst_win_valid", win_valid, 0);
        chk("rst_win_last", win_last, 0);
        chk("rst_done", done, 0);
        chk("rst_iaddr", iaddr, 0);
        chk("rst_addr", addr, 0);
        chk("rst_data_wr", data_wr, 0);
        chk("rst_win_idx", win_idx, 0);
        chk("rst_win_data", win_data, 0);
        ready = 1'b0;
        step();
        reset = 1'b0;
        step();
        chk("post_rst_idle", busy, 0);

        // Partial frame, then asynchronous reset in the middle of a FETCH
        ready = 1'b1;
        step();
        for (int p = 0; p < 3; p++) run_pixel(p, $urandom_range(1, 4), 8'($urandom), 1'b0);
        ready = 1'b0; med_valid = 1'b0;
        repeat (4) step();
        chk("pre_rst_win_valid", win_valid, 1);
        #2 reset = 1'b1;
        #1;
        chk("async_busy", busy, 0);
        chk("async_wen", wen, 0);
        chk("async_win_valid", win_valid, 0);
        chk("async_iaddr", iaddr, 0);
        ready = 1'b1;
        step();
        chk("rst_ready_ignored", busy, 0);
        ready = 1'b0;
        reset = 1'b0;
        step();
        chk("idle_after_rst", busy, 0);
        exp_prev = 0;

        // Full frame from p=0 with random WAIT lengths and medians
        ready = 1'b1;
        step();
        for (int p = 0; p < N; p++) begin
            wt = $urandom_range(1, 4);
            md = 8'($urandom);
            for (int i = 0; i < 3; i++) if (tbl[i].p == p) begin wt = tbl[i].wt; md = tbl[i].md; end
            run_pixel(p, wt, md, 1'b1);
        end

        // Table of fixed scenario addresses and padding
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 9; k++) begin
                if (tbl[i].ia[k] >= 0) chk($sformatf("tbl_iaddr_p%0d_k%0d", tbl[i].p, k), cap_ia[tbl[i].p][k], tbl[i].ia[k]);
                else chk($sformatf("tbl_pad_p%0d_k%0d", tbl[i].p, k), cap_wd[tbl[i].p][k], 0);
            end
        end

        // Stays idle without ready
        step();
        chk("final_idle_busy", busy, 0);
        chk("final_idle_done", done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mfe_scheduler.md
MFE_SCHEDULER -- requirements
Module: mfe_scheduler

Interface
REQ-001 SHALL have parameter IMG_W, default 128, meaning image width in pixels.
REQ-002 SHALL have parameter IMG_H, default 128, meaning image height in pixels; IMG_W*IMG_H <= 16384.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on posedge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high.
REQ-005 SHALL have port ready, input, 1 bit: host start request, sampled only when busy=0.
REQ-006 SHALL have port busy, output, 1 bit: frame in progress.
REQ-007 SHALL have port iaddr, output, 14 bits: source image address, row-major r*IMG_W+c.
REQ-008 SHALL have port idata, input, 8 bits: source pixel; valid one cycle after iaddr is driven.
REQ-009 SHALL have ports win_valid, win_idx, win_data and win_last as outputs of 1, 4, 8 and 1 bits: window element stream to the median datapath.
REQ-010 SHALL have ports med_valid and med_data as inputs of 1 and 8 bits: median result from the datapath.
REQ-011 SHALL have ports wen, addr and data_wr as outputs of 1, 14 and 8 bits: result memory port, where wen=1 is write and wen=0 is read/idle.
REQ-012 SHALL have port done, output, 1 bit: one-cycle frame-complete pulse.

Function
REQ-013 SHALL implement FSM states IDLE, FETCH, WAIT and WRITE.
REQ-014 In IDLE, busy=0; ready=1 at a posedge SHALL move to FETCH with busy=1 from that edge, pixel counter p=0 and neighbour index k=0.
REQ-015 ready SHALL be ignored while busy=1.
REQ-016 FETCH SHALL last exactly 9 cycles, k=0..8, neighbour (dr,dc) = (k/3-1, k%3-1) of pixel p at (r,c).
REQ-017 For an in-bounds neighbour, iaddr SHALL equal (r+dr)*IMG_W+(c+dc); for an out-of-bounds neighbour, iaddr SHALL hold its previous value and the element SHALL be flagged as zero-padded.
REQ-018 In the cycle after each FETCH cycle k, the block SHALL assert win_valid=1 with win_idx=k and win_data=idata, or 0 if the element was flagged; win_last=1 only for k=8.
REQ-019 After k=8, the FSM SHALL enter WAIT; win_valid/win_last for k=8 SHALL be asserted in the first WAIT cycle.
REQ-020 In WAIT, med_valid=1 SHALL latch med_data and go to WRITE; med_valid in any other state SHALL be ignored.
REQ-021 WAIT SHALL have no timeout.
REQ-022 WRITE SHALL last one cycle with wen=1, addr=p and data_wr=the latched median; wen=0 in all other states.
REQ-023 After WRITE, if p < IMG_W*IMG_H-1 the block SHALL increment p and go to FETCH with k=0.
REQ-024 After WRITE, if p = IMG_W*IMG_H-1 the block SHALL go to IDLE, with busy=0 and done=1 for one cycle at the next edge.
REQ-025 Minimum per-pixel latency SHALL be 9 FETCH + 1 WAIT + 1 WRITE = 11 cycles.
REQ-026 Column wrap (c=IMG_W-1 to c=0, r+1) SHALL be produced by the counter increment; no address SHALL exceed IMG_W*IMG_H-1.

Reset
REQ-027 On reset=1, asynchronously: state=IDLE; busy, wen, win_valid, win_last and done=0; iaddr, addr, data_wr, win_idx, win_data and p=0.
REQ-028 Reset mid-frame SHALL abandon the frame; the next ready SHALL restart at p=0.
REQ-029 ready asserted during reset SHALL have no effect.

Verification
REQ-030 Reset scenario: assert reset during FETCH -> same-cycle busy=0, wen=0, win_valid=0; after release and ready, first fetch is for p=0.
REQ-031 Corner p=0 scenario: ready pulse -> busy=1, iaddr sequence 0,1,128,129 on k=4,5,7,8; win_data=0 for k=0,1,2,3,6.
REQ-032 Interior p=129 scenario: iaddr = 0,1,2,128,129,130,256,257,258; win_last only with win_idx=8.
REQ-033 Write scenario: med_valid with med_data=0x5A three cycles into WAIT -> exactly one cycle of wen=1, addr=p, data_wr=0x5A, then FETCH of p+1.
REQ-034 Last-pixel scenario (p=16383): iaddr 16254,16255,16382,16383 on k=0,1,3,4; k=2,5,6,7,8 padded; after WRITE, busy=0 and done pulses once.
REQ-035 Ignored-input scenario: ready while busy and med_valid outside WAIT -> no state change.
